// File: rtl/hd.sv
// Valid/ready capture register with handshake FSM, transfer pulse and transfer counter.
// Optional stall-protocol checker enabled by defining HD_STALL_CHECK_EN.
module hd #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data_src,
  output logic [DATA_WIDTH-1:0] data_dest,
  output logic                  xfer,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  stall_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    XFER = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  xfer_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  fire;

  assign fire = valid && ready;

  // Next state depends only on the current inputs, never on the current state.
  always_comb begin
    state_d = IDLE;
    if (fire)       state_d = XFER;
    else if (valid) state_d = WAIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      xfer_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= fire;
      if (fire) begin
        data_q <= data_src;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign data_dest  = data_q;
  assign xfer       = xfer_q;
  assign state      = state_q;
  assign xfer_count = cnt_q;

`ifdef HD_STALL_CHECK_EN
  logic [DATA_WIDTH-1:0] shadow_q;
  logic                  err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_d == WAIT) shadow_q <= data_src;
      if (state_q == WAIT && (!valid || data_src != shadow_q)) err_q <= 1'b1;
    end
  end

  assign stall_err = err_q;
`else
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_hd.sv
// Directed, scoreboard-checked bench for hd (CNT_WIDTH reduced to 4 to reach wrap quickly).
module tb_hd;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ready = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data_src = '0;
  logic [DW-1:0] data_dest;
  logic          xfer;
  logic [1:0]    state;
  logic [CW-1:0] xfer_count;
  logic          stall_err;

  hd #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .valid      (valid),
    .data_src   (data_src),
    .data_dest  (data_dest),
    .xfer       (xfer),
    .state      (state),
    .xfer_count (xfer_count),
    .stall_err  (stall_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          xfer;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            n_assert = 0;
  int            n_fail   = 0;

  // reference model state
  logic [DW-1:0] m_data = '0;
  logic          m_xfer = 1'b0;
  logic [1:0]    m_st   = 2'b00;
  logic [CW-1:0] m_cnt  = '0;
  logic          m_err  = 1'b0;
  logic [DW-1:0] m_shadow = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_xfer = 1'b0; m_st = 2'b00; m_cnt = '0; m_err = 1'b0; m_shadow = '0;
  endtask

  task automatic push_model();
    exp_t e;
    e.data = m_data; e.xfer = m_xfer; e.st = m_st; e.cnt = m_cnt; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_data"},  32'(data_dest),  32'(e.data));
    check({tag, "_xfer"},  32'(xfer),       32'(e.xfer));
    check({tag, "_state"}, 32'(state),      32'(e.st));
    check({tag, "_cnt"},   32'(xfer_count), 32'(e.cnt));
    check({tag, "_err"},   32'(stall_err),  32'(e.err));
  endtask

  // Drive one cycle of inputs, update the model at the edge, compare after it.
  task automatic step(input string tag, input logic v, input logic r, input logic [DW-1:0] d);
    logic [1:0] nst;
    valid = v; ready = r; data_src = d;
    @(posedge clk);
    nst = (v && r) ? 2'b10 : (v ? 2'b01 : 2'b00);
`ifdef HD_STALL_CHECK_EN
    if (m_st == 2'b01 && (!v || d != m_shadow)) m_err = 1'b1;
    if (nst == 2'b01) m_shadow = d;
`endif
    m_xfer = v && r;
    if (v && r) begin
      m_data = d;
      m_cnt  = m_cnt + 1'b1;
    end
    m_st = nst;
    push_model();
    @(negedge clk);
    compare_out(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    push_model();
    compare_out(tag);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    data_src = 16'd1;
    @(negedge clk);
    async_reset("reset");

    step("stall0", 1'b1, 1'b0, 16'd1);
    step("stall1", 1'b1, 1'b0, 16'd1);
    step("accept", 1'b1, 1'b1, 16'd1);
    step("after_accept", 1'b0, 1'b0, 16'd1);

    for (int i = 0; i < 4; i++) step("vdrop_wait", 1'b1, 1'b0, 16'd5);
    step("vdrop_idle", 1'b0, 1'b0, 16'd5);
    step("vdrop_hold", 1'b0, 1'b0, 16'd5);

    step("b2b_2", 1'b1, 1'b1, 16'd2);
    step("b2b_3", 1'b1, 1'b1, 16'd3);
    step("b2b_4", 1'b1, 1'b1, 16'd4);
    step("b2b_end", 1'b0, 1'b0, 16'd0);

    step("rdy_novalid0", 1'b0, 1'b1, 16'h9999);
    step("rdy_novalid1", 1'b0, 1'b1, 16'h1234);

    async_reset("reset_pre_wrap");
    for (int i = 0; i < 16; i++) step("wrap", 1'b1, 1'b1, DW'(16'hA000 + i));
    step("wrap_idle", 1'b0, 1'b0, 16'd0);
    check("wrap_zero", 32'(xfer_count), 32'd0);

    step("rst_wait0", 1'b1, 1'b0, 16'd7);
    step("rst_wait1", 1'b1, 1'b0, 16'd7);
    async_reset("reset_in_wait");
    step("post_rst_xfer", 1'b1, 1'b1, 16'h00AB);
    step("post_rst_idle", 1'b0, 1'b0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hd.md
# hd

Single-stage valid/ready handshake capture register. On every clock edge where the source asserts `valid` and the sink asserts `ready`, it latches `data_src` into `data_dest` and holds it until the next transfer. It also reports handshake state and transfer statistics. It sits between a producer and a consumer that share one clock, and gives the consumer a registered copy of each accepted word.

## Interface
- `DATA_WIDTH`, 16, width of `data_src` / `data_dest`.
- `CNT_WIDTH`, 16, width of the transfer counter.

Ports:
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ready` in 1: sink ready.
- `valid` in 1: source valid.
- `data_src` in `DATA_WIDTH`: word offered by the source.
- `data_dest` out `DATA_WIDTH`: last accepted word, registered.
- `xfer` out 1: registered pulse, high for one cycle after each accepted transfer.
- `state` out 2: handshake FSM state (00 IDLE, 01 WAIT, 10 XFER).
- `xfer_count` out `CNT_WIDTH`: number of accepted transfers.
- `stall_err` out 1: sticky protocol flag; present only with `HD_STALL_CHECK_EN`, otherwise tied 0.

## Operation
- Transfer condition: `fire = valid && ready`, sampled at the rising edge of `clk`.
- On `fire`:
  - `data_dest` <= `data_src`.
  - `xfer` <= 1.
  - `xfer_count` <= `xfer_count + 1`.
- Otherwise `data_dest` and `xfer_count` hold, and `xfer` <= 0.
- `xfer_count` wraps modulo 2^`CNT_WIDTH`: all-ones + 1 -> 0. There is no saturation.
- FSM next state, evaluated every edge:
  - `fire` -> XFER.
  - `valid && !ready` -> WAIT.
  - `!valid` -> IDLE.
  - This applies from any state. XFER is held across back-to-back transfers.
- `ready` asserted while `valid` is low: no transfer, no state change other than to IDLE.
- `valid` may drop without a transfer (the source withdraws the offer). The block does not enforce this. It only flags it under the configuration macro.
- Data is never buffered. A word offered without `ready` is not retained by the block.
- Reset: all outputs go to 0 and `state` goes to IDLE, immediately on `rst` rising, regardless of `clk`. An in-progress WAIT is abandoned. After `rst` falls, the first edge with `fire` performs a normal transfer.

## Timing
- Latency: `data_dest`, `xfer`, `xfer_count` and `state` update at the same edge where `fire` is sampled. They are visible after the clock-to-q delay, so there is one cycle from the cycle in which the word is offered.
- Throughput: one transfer per clock while `valid` and `ready` both stay high.
- `xfer` is high exactly N cycles for N consecutive fire edges.
- No combinational path from inputs to outputs.

## Configuration
- `HD_STALL_CHECK_EN` defined:
  - A shadow register captures `data_src` whenever FSM is entering or remaining in WAIT.
  - `stall_err` is set (sticky until reset) at any edge where the previous state is WAIT and either:
    - `valid` is now low (offer withdrawn), or
    - `data_src` differs from the shadow (data changed while stalled).
- Not defined: no shadow register, `stall_err` constant 0. All other behaviour is identical.

## Test plan
- Reset: `data_src`=1, pulse `rst` mid-cycle -> immediately `data_dest`=0, `xfer`=0, `xfer_count`=0, `state`=IDLE.
- Stall then accept:
  - `valid`=1, `ready`=0 for 2 cycles -> `state`=WAIT, `data_dest` stays 0.
  - Then `ready`=1 for one cycle with `data_src`=1 -> `data_dest`=1, `xfer` pulses once, `xfer_count`=1, `state`=XFER.
- Valid drop: `valid` high 4 cycles with `ready`=0, then `valid`=0 one cycle -> `state` WAIT then IDLE, no transfer. With `HD_STALL_CHECK_EN`, `stall_err`=1 and held.
- Back-to-back: `valid`=`ready`=1 for 3 cycles, `data_src` = 2, 3, 4 -> `data_dest` = 2, 3, 4 on successive edges, `xfer` high 3 cycles, `xfer_count` +3.
- Ready without valid: `ready`=1, `valid`=0 -> no change to `data_dest` or `xfer_count`, `state`=IDLE.
- Wrap: preload via 2^`CNT_WIDTH` transfers (or use `CNT_WIDTH`=4 and 16 transfers) -> `xfer_count` returns to 0. Async reset asserted during WAIT -> all outputs 0 without waiting for a clock edge.
